cmp_arbiter: RTL
================

# cmp_arbiter

Controller that shares one combinational branch comparator between two requesters: requester 0 is the branch unit (BEQ..BGEU) and requester 1 is the set-less-than unit (SLT/SLTU). It arbitrates round-robin, drives registered operands and the unsigned select into the comparator, samples its equal/less-than flags, and returns a decoded one-bit result over a valid/ready response channel. It sits between the decode/execute control and the comparator instance.

## Interface
- XLEN, 32, operand width
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  XLEN  operands
- req0_op / req1_op  in  3  op: 000 BEQ, 001 BNE, 010 SLT, 011 SLTU, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- cmp_a, cmp_b  out  XLEN  registered operands to comparator
- cmp_un  out  1  unsigned compare select
- cmp_eq, cmp_lt  in  1  comparator flags (combinational from cmp_a/cmp_b/cmp_un)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that owns the result
- rsp_result  out  1  decoded outcome (taken / set)
- rsp_eq, rsp_lt  out  1  raw sampled flags

## Operation
- FSM states: IDLE, CMP, RESP. Reset → IDLE.
- IDLE: if any reqN_valid, grant one. reqN_ready = 1 for the granted requester only, combinationally, in IDLE only. On the handshake, latch a/b into cmp_a/cmp_b, set cmp_un = 1 for op ∈ {011, 110, 111}, else 0. Latch op and id. → CMP.
- CMP (exactly one cycle): sample cmp_eq/cmp_lt into rsp_eq/rsp_lt. Compute rsp_result: BEQ eq; BNE !eq; BLT/SLT/BLTU/SLTU lt; BGE/BGEU !lt. → RESP.
- RESP: rsp_valid = 1; all rsp_* fields and cmp_* held stable. On rsp_valid & rsp_ready → IDLE. No request is accepted while in RESP.
- Arbitration: a single valid requester always wins. If both are valid, grant the requester not named by last_grant, then update last_grant to the winner. last_grant resets to 1, so requester 0 wins the first tie.
- Requesters hold valid/a/b/op stable until ready. The block does not require valid to stay asserted after it is dropped.

## Timing
- Accept at edge N → cmp_* valid from N+1 → rsp_valid at N+2. Minimum latency is 2 cycles. Maximum throughput is one transaction per 3 cycles (IDLE re-entered after the response handshake).
- rsp_ready held low: stay in RESP indefinitely, outputs frozen.
- rst asserted in any state: at the next edge go to IDLE, drop the in-flight transaction, and apply reset values.
- Reset values: reqN_ready 0, cmp_a 0, cmp_b 0, cmp_un 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_eq 0, rsp_lt 0, last_grant 1.
- Both requests valid in the same cycle rsp handshakes: no grant until the next IDLE cycle.

## Configuration
- CMP_ARB_PERF_EN defined:
  - adds outputs perf_cnt0, perf_cnt1 (16 bits each);
  - each counter increments on its requester's accept handshake and saturates at 0xFFFF;
  - each counter resets to 0.
- CMP_ARB_PERF_EN undefined: the counters and their ports do not exist. Functional behaviour is otherwise identical.

## Test plan
- Reset, then idle: all outputs at reset values. Then req0 BEQ a=5 b=5 (model comparator) → req0_ready at cycle 0, cmp_un=0, rsp_valid at +2 with rsp_id=0, rsp_result=1, rsp_eq=1, rsp_lt=0.
- req1 SLTU a=0xFFFFFFFF b=1 → cmp_un=1, rsp_result=0. req0 BLT with the same operands → cmp_un=0, rsp_result=1.
- Both valid every cycle for 4 transactions → grants 0,1,0,1; rsp_id alternates accordingly; each transaction occupies ≥3 cycles.
- rsp_ready low for 5 cycles in RESP → rsp_* and cmp_* constant; both reqN_ready stay 0; completes one cycle after rsp_ready rises.
- rst pulsed during CMP → next cycle IDLE, rsp_valid never asserts for the dropped request, and the next tie goes to req0.
- CMP_ARB_PERF_EN build: 3 req0 and 2 req1 accepts → perf_cnt0=3, perf_cnt1=2. Force perf_cnt0 to 0xFFFF, then accept one more → remains 0xFFFF.

Source files
------------

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin controller sharing one combinational branch
// comparator between the branch unit (requester 0) and the set-less-than
// unit (requester 1).
//
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   reqN_valid/reqN_ready          request handshake (ready only in IDLE, for the winner)
//   reqN_a, reqN_b, reqN_op        operands and 3-bit compare op
//   cmp_a, cmp_b, cmp_un           registered operands / unsigned select to comparator
//   cmp_eq, cmp_lt                 comparator flags
//   rsp_valid/rsp_ready            response handshake
//   rsp_id, rsp_result             owner of the result and decoded outcome
//   rsp_eq, rsp_lt                 raw sampled comparator flags
//   perf_cnt0, perf_cnt1           saturating accept counters (CMP_ARB_PERF_EN only)
//
// Optional feature macro: CMP_ARB_PERF_EN adds the two 16-bit accept counters.
module cmp_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [2:0]      req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [2:0]      req1_op,
  output logic [XLEN-1:0] cmp_a,
  output logic [XLEN-1:0] cmp_b,
  output logic            cmp_un,
  input  logic            cmp_eq,
  input  logic            cmp_lt,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic            rsp_result,
  output logic            rsp_eq,
  output logic            rsp_lt
`ifdef CMP_ARB_PERF_EN
  ,
  output logic [15:0]     perf_cnt0,
  output logic [15:0]     perf_cnt1
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_accept;
  logic [XLEN-1:0] w_sel_a;
  logic [XLEN-1:0] w_sel_b;
  logic [2:0]      w_sel_op;

  logic [XLEN-1:0] r_cmp_a;
  logic [XLEN-1:0] r_cmp_b;
  logic            r_cmp_un;
  logic [2:0]      r_op;
  logic            r_id;
  logic            r_last_grant;
  logic            r_rsp_eq;
  logic            r_rsp_lt;
  logic            r_rsp_result;

  // Unsigned compare for SLTU, BLTU, BGEU.
  function automatic logic f_is_unsigned(input logic [2:0] op);
    f_is_unsigned = (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
  endfunction

  // Map comparator flags onto the taken/set outcome of the op.
  function automatic logic f_decode(input logic [2:0] op, input logic eq, input logic lt);
    case (op)
      3'b000:         f_decode = eq;
      3'b001:         f_decode = !eq;
      3'b101, 3'b111: f_decode = !lt;
      default:        f_decode = lt;
    endcase
  endfunction

  always_comb begin
    w_next_state = r_state;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie the requester not named by last_grant wins.
        if (req0_valid && req1_valid) begin
          w_gnt0 = r_last_grant;
          w_gnt1 = !r_last_grant;
        end else begin
          w_gnt0 = req0_valid;
          w_gnt1 = req1_valid;
        end
        if (w_gnt0 || w_gnt1) w_next_state = S_CMP;
      end
      S_CMP:   w_next_state = S_RESP;
      S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_accept = w_gnt0 | w_gnt1;
  assign w_sel_a  = w_gnt1 ? req1_a  : req0_a;
  assign w_sel_b  = w_gnt1 ? req1_b  : req0_b;
  assign w_sel_op = w_gnt1 ? req1_op : req0_op;

  // Ready is suppressed while reset is asserted so nothing appears accepted.
  assign req0_ready = w_gnt0 & ~rst;
  assign req1_ready = w_gnt1 & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cmp_a      <= '0;
      r_cmp_b      <= '0;
      r_cmp_un     <= 1'b0;
      r_op         <= 3'b000;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_rsp_eq     <= 1'b0;
      r_rsp_lt     <= 1'b0;
      r_rsp_result <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Accept stage: capture the winner's operands for the comparator.
      if (w_accept) begin
        r_cmp_a      <= w_sel_a;
        r_cmp_b      <= w_sel_b;
        r_cmp_un     <= f_is_unsigned(w_sel_op);
        r_op         <= w_sel_op;
        r_id         <= w_gnt1;
        r_last_grant <= w_gnt1;
      end
      // Compare stage: comparator flags settle from the registered operands.
      if (r_state == S_CMP) begin
        r_rsp_eq     <= cmp_eq;
        r_rsp_lt     <= cmp_lt;
        r_rsp_result <= f_decode(r_op, cmp_eq, cmp_lt);
      end
    end
  end

  assign cmp_a      = r_cmp_a;
  assign cmp_b      = r_cmp_b;
  assign cmp_un     = r_cmp_un;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_id;
  assign rsp_result = r_rsp_result;
  assign rsp_eq     = r_rsp_eq;
  assign rsp_lt     = r_rsp_lt;

`ifdef CMP_ARB_PERF_EN
  logic [15:0] r_perf_cnt0;
  logic [15:0] r_perf_cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cnt0 <= '0;
      r_perf_cnt1 <= '0;
    end else begin
      if (w_gnt0 && (r_perf_cnt0 != 16'hFFFF)) r_perf_cnt0 <= r_perf_cnt0 + 16'd1;
      if (w_gnt1 && (r_perf_cnt1 != 16'hFFFF)) r_perf_cnt1 <= r_perf_cnt1 + 16'd1;
    end
  end

  assign perf_cnt0 = r_perf_cnt0;
  assign perf_cnt1 = r_perf_cnt1;
`endif

endmodule
